// File: rtl/ysyx_23060136_pipe_pkg.sv
// Shared types and constants for the IF->ID pipeline segment.
//   if_id_beat_t : default-width {pc, inst} payload carried from IFU to IDU
//   state_e      : occupancy of the IF->ID skid segment
//   PC_RST       : pc value loaded on reset/flush
//   NOP_INST     : instruction loaded on reset/flush (addi x0,x0,0)
package ysyx_23060136_pipe_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;

  localparam logic [PC_W_DEF-1:0]   PC_RST   = 32'h8000_0000;
  localparam logic [INST_W_DEF-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } if_id_beat_t;

  // EMPTY: main invalid; ONE: main valid; TWO: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/skid_reg_slot.sv
// One payload register (pc, inst) plus valid bit.
//   clk, rst          : clock, async active-high reset
//   load_i            : capture pc_i/inst_i, set valid
//   clr_i             : clear valid, payload holds its last value
//   flush_i           : clear valid, payload returns to PC_RST/NOP_INST
//   pc_i, inst_i      : payload to capture
//   valid_o, pc_o, inst_o : registered slot contents
// Priority: flush_i > load_i > clr_i.
module skid_reg_slot #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter logic [PC_W-1:0]   PC_RST   = PC_W'(ysyx_23060136_pipe_pkg::PC_RST),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(ysyx_23060136_pipe_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;

  // Slot register; payload always holds a defined value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RST;
      inst_q  <= NOP_INST;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RST;
      inst_q  <= NOP_INST;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/ifu_idu_skid_seg.sv
// IF->ID pipeline register with valid/ready on both sides and a 2-entry
// skid buffer (main slot M drives out_*, skid slot S holds one overflow
// beat). in_ready is registered so decoder ready never reaches fetch
// combinationally. flush empties the stage and loads PC_RST/NOP_INST.
//   clk, rst                    : clock, async active-high reset
//   flush                       : branch flush, drops held and incoming beats
//   in_valid/in_ready/in_pc/in_inst     : IFU side handshake + payload
//   out_valid/out_ready/out_pc/out_inst : IDU side handshake + payload
//   stall_cnt                   : saturating count of out_valid & ~out_ready
module ifu_idu_skid_seg #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter logic [PC_W-1:0]   PC_RST   = PC_W'(ysyx_23060136_pipe_pkg::PC_RST),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(ysyx_23060136_pipe_pkg::NOP_INST),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  import ysyx_23060136_pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              acc_in_c, acc_out_c;
  logic              m_load, m_clr, s_load, s_clr, seg_flush;
  logic              m_valid, s_valid;
  logic [PC_W-1:0]   s_pc, m_pc_in;
  logic [INST_W-1:0] s_inst, m_inst_in;

  assign acc_in_c  = in_valid & in_ready_q;
  assign acc_out_c = m_valid & out_ready;

  // M refills from S whenever S is occupied, keeping acceptance order
  assign m_pc_in   = s_valid ? s_pc   : in_pc;
  assign m_inst_in = s_valid ? s_inst : in_inst;

  // Next-state and slot control
  always_comb begin
    state_d   = state_q;
    m_load    = 1'b0;
    m_clr     = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    seg_flush = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (acc_in_c) begin
          state_d = ONE;
          m_load  = 1'b1;
        end
      end
      ONE: begin
        if (acc_in_c && acc_out_c) begin
          m_load = 1'b1;
        end else if (acc_in_c) begin
          state_d = TWO;
          s_load  = 1'b1;
        end else if (acc_out_c) begin
          state_d = EMPTY;
          m_clr   = 1'b1;
        end
      end
      TWO: begin
        if (acc_out_c) begin
          state_d = ONE;
          m_load  = 1'b1;
          s_clr   = 1'b1;
        end
      end
      default: begin
        state_d   = EMPTY;
        seg_flush = 1'b1;
      end
    endcase

    // Flush overrides everything; an acc_out this cycle has already completed
    if (flush) begin
      state_d   = EMPTY;
      m_load    = 1'b0;
      m_clr     = 1'b0;
      s_load    = 1'b0;
      s_clr     = 1'b0;
      seg_flush = 1'b1;
    end

    in_ready_d = (state_d != TWO);
  end

  // Saturating stall counter, not affected by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, in_ready and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  skid_reg_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .PC_RST(PC_RST), .NOP_INST(NOP_INST)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .flush_i (seg_flush),
    .pc_i    (m_pc_in),
    .inst_i  (m_inst_in),
    .valid_o (m_valid),
    .pc_o    (out_pc),
    .inst_o  (out_inst)
  );

  skid_reg_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .PC_RST(PC_RST), .NOP_INST(NOP_INST)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (s_load),
    .clr_i   (s_clr),
    .flush_i (seg_flush),
    .pc_i    (in_pc),
    .inst_i  (in_inst),
    .valid_o (s_valid),
    .pc_o    (s_pc),
    .inst_o  (s_inst)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign stall_cnt = stall_cnt_q;

`ifndef SYNTHESIS
  // IFU must hold a stalled beat stable until it is taken (or flushed)
  a_ifu_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready_q && !flush) |=>
      (in_valid && $stable(in_pc) && $stable(in_inst)));
`endif

endmodule

// File: tb/tb_ifu_idu_skid_seg.sv
module tb_ifu_idu_skid_seg;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4;
  logic [31:0] out_pc4, out_inst4;
  logic [3:0]  stall_cnt4;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  ifu_idu_skid_seg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .stall_cnt(stall_cnt)
  );

  ifu_idu_skid_seg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4),
    .out_inst(out_inst4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_ir;
    logic [15:0] e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic ordy, logic fl, logic e_ov, logic [31:0] e_pc,
                              logic [31:0] e_inst, logic e_ir, logic [15:0] e_st);
    vec_t v;
    v.name = nm; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_ir = e_ir; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic e_ov, input logic [31:0] e_pc,
                         input logic [31:0] e_inst, input logic e_ir, input logic [15:0] e_st);
    logic [3:0] e_st4;
    e_st4 = (e_st > 16'd15) ? 4'd15 : e_st[3:0];
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({nm, ".out_pc"},    out_pc,         e_pc);
    chk({nm, ".out_inst"},  out_inst,       e_inst);
    chk({nm, ".in_ready"},  32'(in_ready),  32'(e_ir));
    chk({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(e_st));
    chk({nm, ".out_valid4"}, 32'(out_valid4), 32'(e_ov));
    chk({nm, ".out_pc4"},    out_pc4,         e_pc);
    chk({nm, ".out_inst4"},  out_inst4,       e_inst);
    chk({nm, ".in_ready4"},  32'(in_ready4),  32'(e_ir));
    chk({nm, ".stall_cnt4"}, 32'(stall_cnt4), 32'(e_st4));
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;

    // Basic single beat
    tbl.push_back(mk("single", 1, 32'h8000_0004, 32'h0050_0093, 1, 0,
                     1, 32'h8000_0004, 32'h0050_0093, 1, 0));
    // Streaming: 8 back-to-back beats, no bubbles
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk($sformatf("stream%0d", k), 1, 32'h8000_0000 + 32'(4 * k),
                       32'h1000_0000 + 32'(k), 1, 0,
                       1, 32'h8000_0000 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1, 0));
    end
    // Drain: M invalid, payload holds last beat
    tbl.push_back(mk("drain", 0, 0, 0, 1, 0, 0, 32'h8000_001c, 32'h1000_0007, 1, 0));
    // Backpressure: A then B accepted, B goes to skid
    tbl.push_back(mk("bp_A",   1, 32'h8000_0100, 32'haaaa_0001, 0, 0, 1, 32'h8000_0100, 32'haaaa_0001, 1, 0));
    tbl.push_back(mk("bp_B",   1, 32'h8000_0104, 32'hbbbb_0002, 0, 0, 1, 32'h8000_0100, 32'haaaa_0001, 0, 1));
    tbl.push_back(mk("bp_h1",  0, 0, 0, 0, 0, 1, 32'h8000_0100, 32'haaaa_0001, 0, 2));
    tbl.push_back(mk("bp_h2",  0, 0, 0, 0, 0, 1, 32'h8000_0100, 32'haaaa_0001, 0, 3));
    tbl.push_back(mk("bp_outB", 0, 0, 0, 1, 0, 1, 32'h8000_0104, 32'hbbbb_0002, 1, 3));
    tbl.push_back(mk("bp_empty", 0, 0, 0, 1, 0, 0, 32'h8000_0104, 32'hbbbb_0002, 1, 3));
    // Flush while in TWO with a beat presented
    tbl.push_back(mk("fl_C",   1, 32'h8000_0200, 32'hcccc_0003, 0, 0, 1, 32'h8000_0200, 32'hcccc_0003, 1, 3));
    tbl.push_back(mk("fl_D",   1, 32'h8000_0204, 32'hdddd_0004, 0, 0, 1, 32'h8000_0200, 32'hcccc_0003, 0, 4));
    tbl.push_back(mk("fl_two", 1, 32'h8000_0020, 32'heeee_0005, 0, 1, 0, RST_PC, NOP, 1, 5));
    tbl.push_back(mk("fl_post", 0, 0, 0, 1, 0, 0, RST_PC, NOP, 1, 5));
    // Flush coinciding with acc_out: F consumed, G dropped
    tbl.push_back(mk("fo_F",   1, 32'h8000_0300, 32'hffff_0006, 1, 0, 1, 32'h8000_0300, 32'hffff_0006, 1, 5));
    tbl.push_back(mk("fo_G",   1, 32'h8000_0304, 32'h9999_0007, 1, 1, 0, RST_PC, NOP, 1, 5));
    tbl.push_back(mk("fo_post", 0, 0, 0, 1, 0, 0, RST_PC, NOP, 1, 5));

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, RST_PC, NOP, 1, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy, tbl[i].fl);
      chk_all(tbl[i].name, tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_ir, tbl[i].e_st);
    end

    // Saturation: hold beat H for 20 stalled cycles
    drive(1, 32'h8000_0400, 32'h1234_5678, 0, 0);
    chk_all("sat_load", 1, 32'h8000_0400, 32'h1234_5678, 1, 5);
    for (int c = 0; c < 20; c++) drive(0, 0, 0, 0, 0);
    chk_all("sat_20", 1, 32'h8000_0400, 32'h1234_5678, 1, 25);

    // Push I into skid so in_ready is 0, then async reset mid-cycle
    drive(1, 32'h8000_0404, 32'h8765_4321, 0, 0);
    chk_all("pre_rst", 1, 32'h8000_0400, 32'h1234_5678, 0, 26);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, RST_PC, NOP, 1, 0);
    #1 rst = 1'b0;

    // Recovery after reset
    drive(1, 32'h8000_0004, 32'h0050_0093, 1, 0);
    chk_all("recover", 1, 32'h8000_0004, 32'h0050_0093, 1, 0);
    drive(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
